pll_reset_sequencer: RTL

PLL_RESET_SEQUENCER -- requirements
Module: pll_reset_sequencer

---
 rtl/pll_reset_sequencer.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/pll_reset_sequencer.sv
// PLL reset sequencer: pulses the PLL reset, waits for a stable lock,
// retries on timeout and releases the downstream reset once locked.
module pll_reset_sequencer #(
    parameter int RST_PULSE_CYCLES = 16,
    parameter int LOCK_TIMEOUT     = 50000,
    parameter int STABLE_CYCLES    = 1024,
    parameter int MAX_RETRIES      = 3
) (
    input  logic       refclk,
    input  logic       rst,
    input  logic       pll_locked,
    input  logic       relock_req,
    output logic       pll_rst,
    output logic       sys_rst,
    output logic       ready,
    output logic       fail,
    output logic [1:0] retry_cnt,
    output logic [7:0] lol_count
);

    localparam int MAX_AB = (RST_PULSE_CYCLES > LOCK_TIMEOUT) ?
                            RST_PULSE_CYCLES : LOCK_TIMEOUT;
    localparam int CNT_MAX = (MAX_AB > STABLE_CYCLES) ?
                             MAX_AB : STABLE_CYCLES;
    localparam int CW = (CNT_MAX > 1) ? $clog2(CNT_MAX + 1) : 1;

    localparam logic [CW-1:0] RST_LAST    = CW'(RST_PULSE_CYCLES - 1);
    localparam logic [CW-1:0] LOCK_LAST   = CW'(LOCK_TIMEOUT - 1);
    localparam logic [CW-1:0] STABLE_LAST = CW'(STABLE_CYCLES - 1);
    localparam logic [1:0]    RETRY_MAX   = 2'(MAX_RETRIES);

    // retry_cnt is two bits wide, so more than three retries cannot be counted
    if (MAX_RETRIES > 3 || MAX_RETRIES < 0) begin : g_bad_retries
        $error("pll_reset_sequencer: MAX_RETRIES must be 0..3");
    end

    typedef enum logic [2:0] {
        S_PLL_RST,
        S_WAIT_LOCK,
        S_STABLE,
        S_RUN,
        S_FAIL
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    retry_q, retry_d;
    logic [7:0]    lol_q, lol_d;
    logic          sync1_q, locked_s_q;
    logic          pll_rst_q, pll_rst_d;
    logic          sys_rst_q, sys_rst_d;
    logic          ready_q, ready_d;
    logic          fail_q, fail_d;

    // two-flop synchronizer for the asynchronous lock indication
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            sync1_q    <= 1'b0;
            locked_s_q <= 1'b0;
        end else begin
            sync1_q    <= pll_locked;
            locked_s_q <= sync1_q;
        end
    end

    // next state, shared counter, retry and loss-of-lock bookkeeping
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        retry_d = retry_q;
        lol_d   = lol_q;
        if (relock_req) begin
            state_d = S_PLL_RST;
            cnt_d   = '0;
            retry_d = '0;
        end else begin
            unique case (state_q)
                S_PLL_RST: begin
                    if (cnt_q == RST_LAST) begin
                        state_d = S_WAIT_LOCK;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                S_WAIT_LOCK: begin
                    // lock beats a timeout landing in the same cycle
                    if (locked_s_q) begin
                        state_d = S_STABLE;
                        cnt_d   = '0;
                    end else if (cnt_q == LOCK_LAST) begin
                        cnt_d = '0;
                        if (retry_q == RETRY_MAX) begin
                            state_d = S_FAIL;
                        end else begin
                            state_d = S_PLL_RST;
                            retry_d = retry_q + 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                S_STABLE: begin
                    if (!locked_s_q) begin
                        state_d = S_WAIT_LOCK;
                        cnt_d   = '0;
                    end else if (cnt_q == STABLE_LAST) begin
                        state_d = S_RUN;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                S_RUN: begin
                    cnt_d = '0;
                    if (!locked_s_q) begin
                        state_d = S_PLL_RST;
                        retry_d = '0;
                        if (lol_q != 8'hFF) begin
                            lol_d = lol_q + 8'd1;
                        end
                    end
                end
                S_FAIL: begin
                    cnt_d = '0;
                end
                default: begin
                    state_d = S_PLL_RST;
                    cnt_d   = '0;
                    retry_d = '0;
                end
            endcase
        end
        pll_rst_d = (state_d == S_PLL_RST) || (state_d == S_FAIL);
        sys_rst_d = (state_d != S_RUN);
        ready_d   = (state_d == S_RUN);
        fail_d    = (state_d == S_FAIL);
    end

    // state, counters and registered outputs
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            state_q   <= S_PLL_RST;
            cnt_q     <= '0;
            retry_q   <= '0;
            lol_q     <= '0;
            pll_rst_q <= 1'b1;
            sys_rst_q <= 1'b1;
            ready_q   <= 1'b0;
            fail_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            retry_q   <= retry_d;
            lol_q     <= lol_d;
            pll_rst_q <= pll_rst_d;
            sys_rst_q <= sys_rst_d;
            ready_q   <= ready_d;
            fail_q    <= fail_d;
        end
    end

    assign pll_rst   = pll_rst_q;
    assign sys_rst   = sys_rst_q;
    assign ready     = ready_q;
    assign fail      = fail_q;
    assign retry_cnt = retry_q;
    assign lol_count = lol_q;

endmodule
